// File: rtl/breakout_game_ctrl_pkg.sv
// Shared definitions for the breakout game-flow sequencer: state codes,
// frame-timer default and a single-digit BCD adder helper.
package breakout_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } game_st_e;

    // 2 s of frames at 60 Hz
    localparam int WAIT_FRAMES_60HZ = 120;

    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;

    // Adds two BCD digits plus carry; returns {carry_out, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            s = s + 5'd6;
        end
        return s;
    endfunction

endpackage

// File: rtl/breakout_game_ctrl_bcd_score_counter.sv
// Four-digit BCD score register: synchronous clear, increment by a 1..9
// digit, saturating at 9999 rather than wrapping.
module breakout_game_ctrl_bcd_score_counter
    import breakout_game_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        inc,
    input  logic [3:0]  points,
    output logic [15:0] score_bcd
);

    logic [4:0]  d0, d1, d2, d3;
    logic [15:0] score_next;

    // Ripple the BCD add through the four digits; carry out of the top
    // digit means the sum passed 9999, so clamp.
    always_comb begin
        d0 = bcd_digit_add(score_bcd[3:0],   points,  1'b0);
        d1 = bcd_digit_add(score_bcd[7:4],   4'd0,    d0[4]);
        d2 = bcd_digit_add(score_bcd[11:8],  4'd0,    d1[4]);
        d3 = bcd_digit_add(score_bcd[15:12], 4'd0,    d2[4]);
        if (d3[4]) begin
            score_next = SCORE_MAX_BCD;
        end else begin
            score_next = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
        end
    end

    // Score register: clear wins over increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            score_bcd <= 16'h0000;
        end else if (clr) begin
            score_bcd <= 16'h0000;
        end else if (inc) begin
            score_bcd <= score_next;
        end
    end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game-flow sequencer: start-button synchroniser, frame timer,
// game FSM and lives/level bookkeeping; score lives in the BCD sub-module.
//
//  state    | meaning
//  ---------+------------------------------------------------------
//  ST_IDLE  | attract screen, waiting for start
//  ST_SERVE | ball parked on paddle, waiting for start
//  ST_PLAY  | ball in motion, scoring and misses counted
//  ST_LOST  | life lost, hold WAIT_FRAMES then re-serve
//  ST_CLEAR | level cleared, hold WAIT_FRAMES then load next level
//  ST_OVER  | no lives left, hold WAIT_FRAMES then back to idle
module breakout_game_ctrl
    import breakout_game_ctrl_pkg::*;
#(
    parameter int LIVES_INIT  = 3,
    parameter int LIVES_MAX   = 5,
    parameter int LEVEL_W     = 3,
    parameter int BRICK_W     = 6,
    parameter int WAIT_FRAMES = WAIT_FRAMES_60HZ,
    parameter int POINTS      = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               brick_hit,
    input  logic               ball_miss,
    input  logic [BRICK_W-1:0] bricks_left,
    output logic               gra_still,
    output logic               ball_reset,
    output logic               load_level,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         lives,
    output logic [15:0]        score_bcd,
    output logic [2:0]         game_state
);

    localparam int                 TMR_W        = $clog2(WAIT_FRAMES + 1);
    localparam logic [TMR_W-1:0]   TMR_LOAD     = TMR_W'(WAIT_FRAMES);
    localparam logic [2:0]         LIVES_INIT_V = 3'(LIVES_INIT);
    localparam logic [2:0]         LIVES_MAX_V  = 3'(LIVES_MAX);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP    = '1;

    game_st_e         state;
    logic [TMR_W-1:0] tmr;
    logic             tmr_done;
    logic             start_s1, start_s2, start_s3;
    logic             start_evt;
    logic             score_clr;
    logic             score_inc;

    // Two-flop synchroniser for the asynchronous button, plus one more
    // flop for rising-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
        end
    end

    assign start_evt  = start_s2 & ~start_s3;
    assign tmr_done   = (tmr == '0);
    assign score_clr  = (state == ST_IDLE) && start_evt;
    assign score_inc  = (state == ST_PLAY) && brick_hit;
    assign game_state = state;

    // Game FSM with frame timer, lives/level registers and registered
    // freeze / reload outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            gra_still  <= 1'b1;
            ball_reset <= 1'b0;
            load_level <= 1'b0;
            level      <= '0;
            lives      <= LIVES_INIT_V;
            tmr        <= '0;
        end else begin
            ball_reset <= 1'b0;
            load_level <= 1'b0;
            case (state)
                ST_IDLE: begin
                    gra_still <= 1'b1;
                    if (start_evt) begin
                        lives      <= LIVES_INIT_V;
                        level      <= '0;
                        load_level <= 1'b1;
                        ball_reset <= 1'b1;
                        state      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (start_evt) begin
                        gra_still <= 1'b0;
                        state     <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // An emptied brick field outranks a miss in the same cycle.
                    if (bricks_left == '0) begin
                        gra_still <= 1'b1;
                        tmr       <= TMR_LOAD;
                        level     <= (level == LEVEL_TOP) ? level : level + 1'b1;
                        lives     <= (lives >= LIVES_MAX_V) ? LIVES_MAX_V : lives + 3'd1;
                        state     <= ST_CLEAR;
                    end else if (ball_miss) begin
                        gra_still <= 1'b1;
                        tmr       <= TMR_LOAD;
                        lives     <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                        state     <= (lives <= 3'd1) ? ST_OVER : ST_LOST;
                    end
                end
                ST_LOST: begin
                    if (tmr_done) begin
                        ball_reset <= 1'b1;
                        state      <= ST_SERVE;
                    end else if (frame_tick) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (tmr_done) begin
                        load_level <= 1'b1;
                        ball_reset <= 1'b1;
                        state      <= ST_SERVE;
                    end else if (frame_tick) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_OVER: begin
                    if (tmr_done) begin
                        state <= ST_IDLE;
                    end else if (frame_tick) begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: begin
                    gra_still <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    breakout_game_ctrl_bcd_score_counter u_score (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (score_clr),
        .inc       (score_inc),
        .points    (4'(POINTS)),
        .score_bcd (score_bcd)
    );

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: randomized play against a transaction-level
// model of the game rules (decimal score, lives, level, pulse counts).
module tb_breakout_game_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_SERVE = 1;
    localparam int S_PLAY  = 2;
    localparam int S_LOST  = 3;
    localparam int S_CLEAR = 4;
    localparam int S_OVER  = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        brick_hit = 1'b0;
    logic        ball_miss = 1'b0;
    logic [5:0]  bricks_left = 6'd20;
    logic        gra_still;
    logic        ball_reset;
    logic        load_level;
    logic [2:0]  level;
    logic [2:0]  lives;
    logic [15:0] score_bcd;
    logic [2:0]  game_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_load   = 0;
    int n_ball   = 0;

    int m_state, m_lives, m_level, m_score, m_load, m_ball;

    always #5 clk = ~clk;

    breakout_game_ctrl dut (
        .clk         (clk),
        .rstn        (rstn),
        .frame_tick  (frame_tick),
        .start       (start),
        .brick_hit   (brick_hit),
        .ball_miss   (ball_miss),
        .bricks_left (bricks_left),
        .gra_still   (gra_still),
        .ball_reset  (ball_reset),
        .load_level  (load_level),
        .level       (level),
        .lives       (lives),
        .score_bcd   (score_bcd),
        .game_state  (game_state)
    );

    always @(negedge clk) begin
        if (load_level) n_load++;
        if (ball_reset) n_ball++;
    end

    function automatic logic [15:0] to_bcd(input int v);
        return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
                   (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string where);
        check_val({where, " state"},  32'(game_state), 32'(m_state));
        check_val({where, " lives"},  32'(lives),      32'(m_lives));
        check_val({where, " level"},  32'(level),      32'(m_level));
        check_val({where, " score"},  32'(score_bcd),  32'(to_bcd(m_score)));
        check_val({where, " still"},  32'(gra_still),  32'(m_state != S_PLAY));
        check_val({where, " loads"},  32'(n_load),     32'(m_load));
        check_val({where, " serves"}, 32'(n_ball),     32'(m_ball));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_lives = 3;
        m_level = 0;
        m_score = 0;
    endtask

    task automatic press_start();
        start = 1'b1;
        repeat (10) cyc();
        start = 1'b0;
        repeat (4) cyc();
        if (m_state == S_IDLE) begin
            m_score = 0;
            m_lives = 3;
            m_level = 0;
            m_load++;
            m_ball++;
            m_state = S_SERVE;
        end else if (m_state == S_SERVE) begin
            m_state = S_PLAY;
        end
    endtask

    task automatic ev(input logic h, input logic m, input logic z);
        brick_hit  = h;
        ball_miss  = m;
        frame_tick = (m_state == S_PLAY || m_state == S_SERVE) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (z) bricks_left = 6'd0;
        cyc();
        brick_hit   = 1'b0;
        ball_miss   = 1'b0;
        frame_tick  = 1'b0;
        bricks_left = 6'($urandom_range(1, 63));
        if (m_state == S_PLAY) begin
            if (h) m_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
            if (z) begin
                m_state = S_CLEAR;
                m_level = (m_level == 7) ? 7 : m_level + 1;
                m_lives = (m_lives >= 5) ? 5 : m_lives + 1;
            end else if (m) begin
                m_lives = m_lives - 1;
                m_state = (m_lives == 0) ? S_OVER : S_LOST;
            end
        end
        cyc();
        cyc();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic wait_timer();
        ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        check_all("hold-ignore");
        repeat (119) tick();
        check_val("tick119 state", 32'(game_state), 32'(m_state));
        tick();
        cyc();
        case (m_state)
            S_LOST:  begin m_state = S_SERVE; m_ball++; end
            S_CLEAR: begin m_state = S_SERVE; m_ball++; m_load++; end
            S_OVER:  m_state = S_IDLE;
            default: ;
        endcase
        check_all("tick120");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        m_load = 0;
        m_ball = 0;
        model_reset();

        repeat (3) cyc();
        check_all("reset");
        rstn = 1'b1;
        cyc();

        press_start();
        check_all("start1");
        press_start();
        check_all("start2");

        repeat (12) begin
            ev(1'b1, 1'b0, 1'b0);
            repeat ($urandom_range(0, 3)) cyc();
        end
        check_val("score12", 32'(score_bcd), 32'h0012);

        for (int i = 0; i < 40; i++) begin
            if (m_state == S_PLAY) begin
                r = $urandom_range(0, 99);
                if (r < 55)      ev(1'b1, 1'b0, 1'b0);
                else if (r < 70) ev(1'b0, 1'b1, 1'b0);
                else if (r < 80) ev(1'b1, 1'b1, 1'b0);
                else if (r < 88) ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
                else             cyc();
                check_all("rand");
                if (m_state == S_LOST || m_state == S_CLEAR || m_state == S_OVER)
                    wait_timer();
            end else if (m_state == S_SERVE) begin
                ev(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                check_all("serve-ignore");
                press_start();
            end else begin
                press_start();
            end
        end

        // Settle into a fresh game.
        while (m_state != S_IDLE) begin
            if (m_state == S_PLAY) ev(1'b0, 1'b1, 1'b0);
            else if (m_state == S_SERVE) press_start();
            else wait_timer();
        end
        press_start();
        press_start();
        ev(1'b0, 1'b1, 1'b0);
        wait_timer();
        press_start();
        check_all("lives2");
        ev(1'b1, 1'b1, 1'b1);
        check_all("clear-combo");
        wait_timer();

        press_start();
        while (m_state != S_OVER) begin
            ev(1'b0, 1'b1, 1'b0);
            if (m_state == S_LOST) begin
                wait_timer();
                press_start();
            end
        end
        check_all("over");
        wait_timer();

        press_start();
        press_start();
        brick_hit = 1'b1;
        repeat (9998) cyc();
        brick_hit = 1'b0;
        cyc();
        cyc();
        m_score = 9998;
        check_all("score9998");
        repeat (3) ev(1'b1, 1'b0, 1'b0);
        check_all("score-sat");

        repeat (8) begin
            ev(1'b0, 1'b0, 1'b1);
            wait_timer();
            press_start();
        end
        check_all("level-sat");

        rstn = 1'b0;
        cyc();
        model_reset();
        check_all("reset-mid");
        rstn = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
